// File: rtl/at93c46d_pkg.sv
// Shared types and command encodings for the AT93C46D (x16) transaction sequencer.
package at93c46d_pkg;

    typedef enum logic [2:0] {
        OP_READ  = 3'd0,
        OP_WRITE = 3'd1,
        OP_ERASE = 3'd2,
        OP_WRAL  = 3'd3,
        OP_ERAL  = 3'd4
    } op_t;

    localparam logic [1:0] OPC_EXT   = 2'b00;
    localparam logic [1:0] OPC_WRITE = 2'b01;
    localparam logic [1:0] OPC_READ  = 2'b10;
    localparam logic [1:0] OPC_ERASE = 2'b11;

    localparam logic [7:0] CMD_EWEN = 8'h30;
    localparam logic [7:0] CMD_EWDS = 8'h00;
    localparam logic [7:0] CMD_WRAL = 8'h10;
    localparam logic [7:0] CMD_ERAL = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_PROG,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        STEP_EWEN,
        STEP_MAIN,
        STEP_EWDS
    } step_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

    function automatic logic op_has_data(input logic [2:0] op);
        return (op == OP_WRITE) || (op == OP_WRAL);
    endfunction

    // Engine command word for the operation itself (not the EWEN/EWDS wrapper).
    function automatic logic [7:0] main_cmd(input logic [2:0] op, input logic [5:0] addr);
        case (op)
            OP_READ:  return {OPC_READ, addr};
            OP_WRITE: return {OPC_WRITE, addr};
            OP_ERASE: return {OPC_ERASE, addr};
            OP_WRAL:  return CMD_WRAL;
            OP_ERAL:  return CMD_ERAL;
            default:  return {OPC_EXT, 6'd0};
        endcase
    endfunction

endpackage

// File: rtl/at93c46d_xfer_watch.sv
// Supervises one engine transfer: waits for eng_busy to rise (bounded by
// START_TIMEOUT) and then to fall, reporting done or timeout.
module at93c46d_xfer_watch
    import at93c46d_pkg::*;
#(
    parameter int START_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic eng_busy,
    output logic done,
    output logic timeout
);

    localparam int CW = $clog2(START_TIMEOUT + 1);

    logic          active;
    logic          seen;
    logic [CW-1:0] cnt;

    assign done    = active && seen && !eng_busy;
    assign timeout = active && !seen && !eng_busy && (cnt >= CW'(START_TIMEOUT));

    // An engine already busy on the start cycle counts as the start being seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            seen   <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            seen   <= eng_busy;
            cnt    <= CW'(1);
        end else if (active) begin
            if (done || timeout) begin
                active <= 1'b0;
            end else begin
                if (eng_busy)
                    seen <= 1'b1;
                if (cnt != CW'(START_TIMEOUT))
                    cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/at93c46d_ctrl.sv
// Host-side sequencer for the AT93C46D bit engine: expands one high-level
// operation into EWEN / op / programming wait / EWDS and reports the result.
module at93c46d_ctrl
    import at93c46d_pkg::*;
#(
    parameter int T_WP_CYCLES   = 1250000,
    parameter int START_TIMEOUT = 16,
    parameter int TWP_W         = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [5:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic        eng_start,
    output logic [7:0]  eng_cmd,
    output logic [15:0] eng_wdata,
    input  logic        eng_busy,
    input  logic [15:0] eng_rdata
);

    state_t           state;
    step_t            step;
    logic [2:0]       op_q;
    logic [5:0]       addr_q;
    logic [15:0]      wdata_q;
    logic             err_q;
    logic [TWP_W-1:0] prog_cnt;
    logic             xfer_done;
    logic             xfer_timeout;

    at93c46d_xfer_watch #(
        .START_TIMEOUT(START_TIMEOUT)
    ) u_watch (
        .clk     (clk),
        .rst     (rst),
        .start   (eng_start),
        .eng_busy(eng_busy),
        .done    (xfer_done),
        .timeout (xfer_timeout)
    );

    // eng_start is raised together with the move into ISSUE so the pulse
    // coincides with that state; eng_cmd/eng_wdata then hold until the next ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            step       <= STEP_EWEN;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            prog_cnt   <= '0;
            cmd_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
            eng_start  <= 1'b0;
            eng_cmd    <= '0;
            eng_wdata  <= '0;
        end else begin
            eng_start  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        err_q     <= !op_is_legal(cmd_op);
                        if (!op_is_legal(cmd_op)) begin
                            state <= ST_DONE;
                        end else begin
                            eng_start <= 1'b1;
                            eng_wdata <= '0;
                            state     <= ST_ISSUE;
                            if (cmd_op == OP_READ) begin
                                step    <= STEP_MAIN;
                                eng_cmd <= main_cmd(cmd_op, cmd_addr);
                            end else begin
                                step    <= STEP_EWEN;
                                eng_cmd <= CMD_EWEN;
                            end
                        end
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    // A READ never enabled writes, so its timeout needs no EWDS.
                    if (xfer_timeout) begin
                        err_q <= 1'b1;
                        if (step == STEP_EWDS || op_q == OP_READ) begin
                            state <= ST_DONE;
                        end else begin
                            step      <= STEP_EWDS;
                            eng_cmd   <= CMD_EWDS;
                            eng_wdata <= '0;
                            eng_start <= 1'b1;
                            state     <= ST_ISSUE;
                        end
                    end else if (xfer_done) begin
                        case (step)
                            STEP_EWEN: begin
                                step      <= STEP_MAIN;
                                eng_cmd   <= main_cmd(op_q, addr_q);
                                eng_wdata <= op_has_data(op_q) ? wdata_q : 16'h0000;
                                eng_start <= 1'b1;
                                state     <= ST_ISSUE;
                            end
                            STEP_MAIN: begin
                                if (op_q == OP_READ) begin
                                    resp_rdata <= eng_rdata;
                                    state      <= ST_DONE;
                                end else begin
                                    prog_cnt <= TWP_W'(T_WP_CYCLES - 1);
                                    state    <= ST_PROG;
                                end
                            end
                            default: state <= ST_DONE;
                        endcase
                    end
                end
                ST_PROG: begin
                    if (prog_cnt == '0) begin
                        step      <= STEP_EWDS;
                        eng_cmd   <= CMD_EWDS;
                        eng_wdata <= '0;
                        eng_start <= 1'b1;
                        state     <= ST_ISSUE;
                    end else begin
                        prog_cnt <= prog_cnt - TWP_W'(1);
                    end
                end
                ST_DONE: begin
                    resp_valid <= 1'b1;
                    resp_err   <= err_q;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_at93c46d_ctrl.sv
// Self-checking bench: a behavioural EEPROM engine plus a word-level memory
// model predicting read data, command sequences and response timing.
module tb_at93c46d_ctrl;

    localparam int TWP = 8;
    localparam int STO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [5:0]  cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        eng_start;
    logic [7:0]  eng_cmd;
    logic [15:0] eng_wdata;
    logic        eng_busy;
    logic [15:0] eng_rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    at93c46d_ctrl #(
        .T_WP_CYCLES  (TWP),
        .START_TIMEOUT(STO),
        .TWP_W        (24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_cmd   (eng_cmd),
        .eng_wdata (eng_wdata),
        .eng_busy  (eng_busy),
        .eng_rdata (eng_rdata)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: a real 93C46 x16 array with write-enable latch.
    logic [15:0] eng_mem [64];
    bit          eng_ewen = 1'b0;
    bit          mute_write = 1'b0;
    bit          eng_pending = 1'b0;
    int          eng_left = 0;
    logic [7:0]  cur_cmd;
    logic [15:0] cur_wd;
    logic [7:0]  log_cmd [$];
    logic [15:0] log_wd [$];
    int          log_cyc [$];
    int          fall_log [$];

    logic [15:0] ref_mem [64];
    logic [15:0] last_rdata = '0;

    task engine_execute(input logic [7:0] c, input logic [15:0] d);
        case (c[7:6])
            2'b10: eng_rdata = eng_mem[c[5:0]];
            2'b01: if (eng_ewen) eng_mem[c[5:0]] = d;
            2'b11: if (eng_ewen) eng_mem[c[5:0]] = 16'hFFFF;
            default: begin
                case (c[5:4])
                    2'b11: eng_ewen = 1'b1;
                    2'b00: eng_ewen = 1'b0;
                    2'b01: if (eng_ewen) for (int i = 0; i < 64; i++) eng_mem[i] = d;
                    default: if (eng_ewen) for (int i = 0; i < 64; i++) eng_mem[i] = 16'hFFFF;
                endcase
            end
        endcase
    endtask

    initial begin
        eng_busy = 1'b0;
        eng_rdata = '0;
        for (int i = 0; i < 64; i++) begin
            eng_mem[i] = 16'hFFFF;
            ref_mem[i] = 16'hFFFF;
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                eng_busy = 1'b0;
                eng_left = 0;
                eng_pending = 1'b0;
            end else begin
                if (eng_left > 0) begin
                    eng_left--;
                    if (eng_left == 0) begin
                        eng_busy = 1'b0;
                        fall_log.push_back(cyc);
                        engine_execute(cur_cmd, cur_wd);
                    end
                end else if (eng_pending) begin
                    eng_pending = 1'b0;
                    eng_busy = 1'b1;
                    eng_left = $urandom_range(1, 4);
                end
                if (eng_start === 1'b1) begin
                    log_cmd.push_back(eng_cmd);
                    log_wd.push_back(eng_wdata);
                    log_cyc.push_back(cyc);
                    if (!(mute_write && eng_cmd[7:6] == 2'b01)) begin
                        cur_cmd = eng_cmd;
                        cur_wd = eng_wdata;
                        if ($urandom_range(0, 3) == 0) begin
                            eng_busy = 1'b1;
                            eng_left = $urandom_range(1, 4);
                        end else begin
                            eng_pending = 1'b1;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [7:0] ref_main(input logic [2:0] op, input logic [5:0] a);
        case (op)
            3'd0:    return {2'b10, a};
            3'd1:    return {2'b01, a};
            3'd2:    return {2'b11, a};
            3'd3:    return 8'h10;
            default: return 8'h20;
        endcase
    endfunction

    task ref_apply(input logic [2:0] op, input logic [5:0] a, input logic [15:0] d);
        case (op)
            3'd1: ref_mem[a] = d;
            3'd2: ref_mem[a] = 16'hFFFF;
            3'd3: for (int i = 0; i < 64; i++) ref_mem[i] = d;
            3'd4: for (int i = 0; i < 64; i++) ref_mem[i] = 16'hFFFF;
            default: ;
        endcase
    endtask

    task clear_logs();
        log_cmd.delete();
        log_wd.delete();
        log_cyc.delete();
        fall_log.delete();
    endtask

    // Drives one request from a negedge and waits (bounded) for its response.
    task automatic applyStimulus(input logic [2:0] op, input logic [5:0] a, input logic [15:0] d,
                                 output logic [15:0] rdata, output logic err,
                                 output int acc, output int rsp, output bit ok);
        int n;
        clear_logs();
        ok = 1'b0; rdata = 'x; err = 1'bx; rsp = -1;
        cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (cmd_ready === 1'b1) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            n = 0;
            while (resp_valid !== 1'b1 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            if (resp_valid === 1'b1) begin
                ok = 1'b1; rsp = cyc; rdata = resp_rdata; err = resp_err;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, resp_valid, resp_rdata, resp_err, busy, eng_start, eng_cmd, eng_wdata} !== 45'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h required 0",
                     {cmd_ready, resp_valid, resp_rdata, resp_err, busy, eng_start, eng_cmd, eng_wdata});
        end
        rst = 1'b0;
        last_rdata = '0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready: got ready=%b busy=%b required ready=1 busy=0", cmd_ready, busy);
        end
    endtask

    task automatic test_read();
        logic [15:0] rd; logic err; int acc, rsp; bit ok;
        eng_mem[5] = 16'hBEEF;
        ref_mem[5] = 16'hBEEF;
        applyStimulus(3'd0, 6'h05, 16'h0, rd, err, acc, rsp, ok);
        checks++;
        if (!ok || rd !== 16'hBEEF || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_resp: got ok=%0d rdata=%h err=%b required rdata=beef err=0", ok, rd, err);
        end
        checks++;
        if (log_cmd.size() != 1 || log_cmd[0] !== 8'h85) begin
            failures++;
            $display("[TB] FAIL read_cmd: got %0d starts first=%h required 1 start 85", log_cmd.size(), log_cmd[0]);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_busy_after: got %b required 0", busy);
        end
        last_rdata = 16'hBEEF;
    endtask

    task automatic test_write();
        logic [15:0] rd; logic err; int acc, rsp; bit ok;
        applyStimulus(3'd1, 6'h3F, 16'h1234, rd, err, acc, rsp, ok);
        ref_apply(3'd1, 6'h3F, 16'h1234);
        checks++;
        if (!ok || err !== 1'b0 || rd !== last_rdata) begin
            failures++;
            $display("[TB] FAIL write_resp: got ok=%0d err=%b rdata=%h required err=0 rdata=%h", ok, err, rd, last_rdata);
        end
        checks++;
        if (log_cmd.size() != 3 || log_cmd[0] !== 8'h30 || log_cmd[1] !== 8'h7F || log_cmd[2] !== 8'h00
            || log_wd[1] !== 16'h1234) begin
            failures++;
            $display("[TB] FAIL write_seq: got n=%0d %h %h %h wd=%h required 30 7f 00 wd=1234",
                     log_cmd.size(), log_cmd[0], log_cmd[1], log_cmd[2], log_wd[1]);
        end
        // TWP idle cycles lie strictly between the write's busy fall and the EWDS start.
        checks++;
        if (log_cyc[2] - fall_log[1] != TWP + 1) begin
            failures++;
            $display("[TB] FAIL write_twp_gap: got %0d required %0d", log_cyc[2] - fall_log[1], TWP + 1);
        end
        applyStimulus(3'd0, 6'h3F, 16'h0, rd, err, acc, rsp, ok);
        checks++;
        if (!ok || rd !== ref_mem[6'h3F] || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL write_readback: got %h required %h", rd, ref_mem[6'h3F]);
        end
        last_rdata = ref_mem[6'h3F];
    endtask

    task automatic test_illegal();
        logic [15:0] rd; logic err; int acc, rsp; bit ok;
        applyStimulus(3'd6, 6'h11, 16'h5555, rd, err, acc, rsp, ok);
        checks++;
        if (!ok || err !== 1'b1 || rsp - acc != 2) begin
            failures++;
            $display("[TB] FAIL illegal_resp: got ok=%0d err=%b latency=%0d required err=1 latency=2", ok, err, rsp - acc);
        end
        checks++;
        if (log_cmd.size() != 0 || rd !== last_rdata) begin
            failures++;
            $display("[TB] FAIL illegal_quiet: got starts=%0d rdata=%h required 0 starts rdata=%h", log_cmd.size(), rd, last_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int n, acc1, acc2, rsp1, rsp2;
        bit overlap;
        logic e1, e2;
        logic [7:0] exp_seq [6];
        exp_seq = '{8'h30, 8'h20, 8'h00, 8'h30, 8'h10, 8'h00};
        clear_logs();
        acc1 = -1; acc2 = -1; rsp1 = -1; rsp2 = -1; overlap = 1'b0; e1 = 1'bx; e2 = 1'bx;
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_addr = 6'h00; cmd_wdata = 16'h0;
        n = 0;
        while (n < 3000 && rsp2 < 0) begin
            if (cmd_ready === 1'b1 && resp_valid === 1'b1) overlap = 1'b1;
            if (cmd_ready === 1'b1 && cmd_valid) begin
                if (acc1 < 0) acc1 = cyc; else acc2 = cyc;
            end
            if (resp_valid === 1'b1) begin
                if (rsp1 < 0) begin rsp1 = cyc; e1 = resp_err; end
                else begin rsp2 = cyc; e2 = resp_err; end
            end
            @(negedge clk);
            n++;
            if (acc1 >= 0 && acc2 < 0) begin cmd_op = 3'd3; cmd_wdata = 16'hA5A5; end
            if (acc2 >= 0) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        ref_apply(3'd4, 6'h0, 16'h0);
        ref_apply(3'd3, 6'h0, 16'hA5A5);
        checks++;
        if (rsp2 < 0 || acc2 <= rsp1) begin
            failures++;
            $display("[TB] FAIL b2b_order: got rsp1=%0d acc2=%0d rsp2=%0d required acc2>rsp1 and both responses", rsp1, acc2, rsp2);
        end
        checks++;
        if (overlap || e1 !== 1'b0 || e2 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_resp: got overlap=%0d err1=%b err2=%b required 0 0 0", overlap, e1, e2);
        end
        checks++;
        if (log_cmd.size() != 6) begin
            failures++;
            $display("[TB] FAIL b2b_count: got %0d starts required 6", log_cmd.size());
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (log_cmd[k] !== exp_seq[k]) begin
                failures++;
                $display("[TB] FAIL b2b_cmd%0d: got %h required %h", k, log_cmd[k], exp_seq[k]);
            end
        end
        checks++;
        if (log_wd[4] !== 16'hA5A5) begin
            failures++;
            $display("[TB] FAIL b2b_wral_data: got %h required a5a5", log_wd[4]);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] rd; logic err; int acc, rsp; bit ok;
        logic [15:0] d;
        d = 16'($urandom);
        mute_write = 1'b1;
        applyStimulus(3'd1, 6'h10, d, rd, err, acc, rsp, ok);
        mute_write = 1'b0;
        checks++;
        if (!ok || err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_err: got ok=%0d err=%b required err=1", ok, err);
        end
        checks++;
        if (log_cmd.size() != 3 || log_cmd[0] !== 8'h30 || log_cmd[1] !== 8'h50 || log_cmd[2] !== 8'h00) begin
            failures++;
            $display("[TB] FAIL timeout_seq: got n=%0d %h %h %h required 30 50 00",
                     log_cmd.size(), log_cmd[0], log_cmd[1], log_cmd[2]);
        end
        // Timeout fires STO cycles after the start; EWDS follows on the next cycle.
        checks++;
        if (log_cyc[2] - log_cyc[1] != STO + 1) begin
            failures++;
            $display("[TB] FAIL timeout_delay: got %0d required %0d", log_cyc[2] - log_cyc[1], STO + 1);
        end
    endtask

    task automatic test_reset_prog();
        logic [15:0] rd; logic err; int acc, rsp, n; bit ok;
        logic [5:0] a;
        logic [15:0] d;
        a = 6'($urandom);
        d = 16'($urandom);
        clear_logs();
        cmd_op = 3'd1; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (fall_log.size() < 2 && n < 500) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        checks++;
        if (fall_log.size() != 2 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstprog_reached: got transfers=%0d busy=%b required 2 and busy=1", fall_log.size(), busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, resp_valid, resp_rdata, resp_err, busy, eng_start, eng_cmd, eng_wdata} !== 45'd0) begin
            failures++;
            $display("[TB] FAIL rstprog_outputs: got %h required 0",
                     {cmd_ready, resp_valid, resp_rdata, resp_err, busy, eng_start, eng_cmd, eng_wdata});
        end
        rst = 1'b0;
        last_rdata = '0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstprog_ready: got ready=%b busy=%b required 1 0", cmd_ready, busy);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (log_cmd.size() != 2) begin
            failures++;
            $display("[TB] FAIL rstprog_no_ewds: got %0d starts required 2", log_cmd.size());
        end
        ref_mem[a] = d;
        applyStimulus(3'd0, a, 16'h0, rd, err, acc, rsp, ok);
        checks++;
        if (!ok || rd !== d || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstprog_read: got ok=%0d rdata=%h err=%b required %h err=0", ok, rd, err, d);
        end
        last_rdata = d;
    endtask

    task automatic test_random();
        logic [15:0] rd; logic err; int acc, rsp; bit ok;
        logic [2:0] op; logic [5:0] a; logic [15:0] d;
        logic [7:0] exp_cmd [3];
        int exp_n, r;
        bit legal;
        for (int it = 0; it < 16; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: op = 3'd0;
                4, 5:       op = 3'd1;
                6:          op = 3'd2;
                7:          op = 3'd3;
                8:          op = 3'd4;
                default:    op = 3'($urandom_range(5, 7));
            endcase
            a = 6'($urandom);
            d = 16'($urandom);
            legal = (op <= 3'd4);
            exp_n = !legal ? 0 : (op == 3'd0 ? 1 : 3);
            if (op == 3'd0) exp_cmd[0] = ref_main(op, a);
            else begin exp_cmd[0] = 8'h30; exp_cmd[1] = ref_main(op, a); exp_cmd[2] = 8'h00; end
            applyStimulus(op, a, d, rd, err, acc, rsp, ok);
            checks++;
            if (!ok || err !== !legal) begin
                failures++;
                $display("[TB] FAIL rand%0d_err: op=%0d got ok=%0d err=%b required err=%b", it, op, ok, err, !legal);
            end
            if (op == 3'd0) last_rdata = ref_mem[a];
            checks++;
            if (rd !== last_rdata) begin
                failures++;
                $display("[TB] FAIL rand%0d_rdata: op=%0d addr=%h got %h required %h", it, op, a, rd, last_rdata);
            end
            checks++;
            if (log_cmd.size() != exp_n) begin
                failures++;
                $display("[TB] FAIL rand%0d_count: op=%0d got %0d starts required %0d", it, op, log_cmd.size(), exp_n);
            end
            for (int k = 0; k < exp_n; k++) begin
                checks++;
                if (log_cmd[k] !== exp_cmd[k]) begin
                    failures++;
                    $display("[TB] FAIL rand%0d_cmd%0d: got %h required %h", it, k, log_cmd[k], exp_cmd[k]);
                end
            end
            if (op == 3'd1 || op == 3'd3) begin
                checks++;
                if (log_wd[1] !== d) begin
                    failures++;
                    $display("[TB] FAIL rand%0d_wdata: got %h required %h", it, log_wd[1], d);
                end
            end
            ref_apply(op, a, d);
        end
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rand_idle: got busy=%b ready=%b required 0 1", busy, cmd_ready);
        end
    endtask

    initial begin
        $display("[TB] starting at93c46d_ctrl bench");
        test_reset();
        test_read();
        test_write();
        test_illegal();
        test_back_to_back();
        test_timeout();
        test_reset_prog();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
